// File: rtl/ez8_test_runner.sv
// ez8_test_runner: loads, resets, runs and grades a session of ez8 programs.
// Optional watchdog in RUN: define EZ8_TEST_RUNNER_TIMEOUT_EN.
module ez8_test_runner #(
  parameter int         INSTR_WIDTH    = 16,
  parameter int         ADDR_WIDTH     = 12,
  parameter int         NUM_PROGS      = 3,
  parameter int         RESET_CYCLES   = 1,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter logic [7:0] EXPECT_ACCUM   = 8'd0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [INSTR_WIDTH-1:0]         prog_data,
  input  logic                           prog_valid,
  input  logic                           prog_last,
  output logic                           prog_ready,
  output logic [ADDR_WIDTH-1:0]          instr_writeaddr,
  output logic [INSTR_WIDTH-1:0]         instr_writedata,
  output logic                           instr_write_en,
  output logic                           cpu_pause,
  output logic                           cpu_reset,
  input  logic                           cpu_stopped,
  input  logic                           cpu_error,
  input  logic [7:0]                     cpu_accum,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_PROGS+1)-1:0] pass_count,
  output logic [NUM_PROGS-1:0]           fail_mask
);

  localparam int IDX_W =
    (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam int RC_W =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_PROGS - 1);
  localparam logic [RC_W-1:0] RC_LAST =
    RC_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  if (NUM_PROGS < 1 || RESET_CYCLES < 1 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ez8_test_runner: illegal parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RESET,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic                  hs;
  logic                  begin_session;
  logic                  grade_ok;
  logic                  tmo_hit;
  logic [ADDR_WIDTH-1:0] addr;
  logic [IDX_W-1:0]      idx;
  logic [RC_W-1:0]       rst_cnt;
  logic                  run_first;
  logic                  ovf;
  logic                  tmo;

  logic pause_nx;
  logic reset_nx;
  logic ready_nx;
  logic busy_nx;
  logic done_nx;

  assign hs = prog_valid & prog_ready;

  assign begin_session = start &
    ((state == S_IDLE) | (state == S_DONE));

  assign grade_ok = !cpu_error &&
    (cpu_accum == EXPECT_ACCUM) && !tmo && !ovf;

`ifdef EZ8_TEST_RUNNER_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TC_W-1:0] TC_LAST =
    TC_W'(TIMEOUT_CYCLES - 1);

  logic [TC_W-1:0] run_cnt;

  // Watchdog: counts RUN cycles, zero in the first one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (state != S_RUN) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // A stop in the same cycle as the limit wins.
  assign tmo_hit = (state == S_RUN) &&
    (run_cnt == TC_LAST) && !cpu_stopped;
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and next-cycle control outputs.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (hs) begin
          if (prog_last) begin
            state_nx = S_RESET;
          end else if (addr == ADDR_MAX) begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (hs && prog_last) state_nx = S_CHECK;
      end
      S_RESET: begin
        if (rst_cnt == RC_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        if (!run_first && cpu_stopped) begin
          state_nx = S_CHECK;
        end else if (tmo_hit) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (idx == LAST_IDX) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    pause_nx = 1'b1;
    reset_nx = 1'b0;
    ready_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    unique case (1'b1)
      (state_nx == S_LOAD),
      (state_nx == S_DRAIN): begin
        ready_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      (state_nx == S_RESET): begin
        pause_nx = 1'b0;
        reset_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      (state_nx == S_RUN): begin
        pause_nx = 1'b0;
        busy_nx  = 1'b1;
      end
      (state_nx == S_CHECK): begin
        busy_nx  = 1'b1;
      end
      (state_nx == S_DONE): begin
        done_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered control outputs; the CPU is held in reset while we are.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pause  <= 1'b1;
      cpu_reset  <= 1'b1;
      prog_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cpu_pause  <= pause_nx;
      cpu_reset  <= reset_nx;
      prog_ready <= ready_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Reset hold counter and first-RUN-cycle marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt   <= '0;
      run_first <= 1'b0;
    end else begin
      if (state == S_RESET) begin
        rst_cnt <= rst_cnt + 1'b1;
      end else begin
        rst_cnt <= '0;
      end
      run_first <= (state_nx == S_RUN) &&
        (state != S_RUN);
    end
  end

  // Write port, program index, flags and grading.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_write_en  <= 1'b0;
      instr_writeaddr <= '0;
      instr_writedata <= '0;
      addr            <= '0;
      idx             <= '0;
      ovf             <= 1'b0;
      tmo             <= 1'b0;
      pass_count      <= '0;
      fail_mask       <= '0;
    end else begin
      instr_write_en <= (state == S_LOAD) && hs;
      if ((state == S_LOAD) && hs) begin
        instr_writeaddr <= addr;
        instr_writedata <= prog_data;
        addr            <= addr + 1'b1;
        if (!prog_last && (addr == ADDR_MAX)) begin
          ovf <= 1'b1;
        end
      end
      if (tmo_hit) begin
        tmo <= 1'b1;
      end
      if (begin_session) begin
        pass_count <= '0;
        fail_mask  <= '0;
        idx        <= '0;
        addr       <= '0;
        ovf        <= 1'b0;
        tmo        <= 1'b0;
      end
      if (state == S_CHECK) begin
        if (grade_ok) begin
          pass_count <= pass_count + 1'b1;
        end else begin
          fail_mask <= fail_mask |
            (NUM_PROGS'(1) << idx);
        end
        addr <= '0;
        ovf  <= 1'b0;
        tmo  <= 1'b0;
        if (idx != LAST_IDX) begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ez8_test_runner.sv
// tb_ez8_test_runner: random programs against a session-level model.
// Watchdog expectations follow EZ8_TEST_RUNNER_TIMEOUT_EN.
module tb_ez8_test_runner;

  localparam int IW    = 16;
  localparam int AW    = 3;
  localparam int NP    = 3;
  localparam int RC    = 2;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;
  localparam int NEVER = 0;
`ifdef EZ8_TEST_RUNNER_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int ABORT_AT = WDOG ? 8 : 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] prog_data = '0;
  logic          prog_valid = 1'b0;
  logic          prog_last = 1'b0;
  logic          prog_ready;
  logic [AW-1:0] instr_writeaddr;
  logic [IW-1:0] instr_writedata;
  logic          instr_write_en;
  logic          cpu_pause;
  logic          cpu_reset;
  logic          cpu_stopped = 1'b0;
  logic          cpu_error = 1'b0;
  logic [7:0]    cpu_accum = 8'd0;
  logic          busy;
  logic          done;
  logic [1:0]    pass_count;
  logic [NP-1:0] fail_mask;

  ez8_test_runner #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .NUM_PROGS(NP),
    .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO),
    .EXPECT_ACCUM(8'd0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .prog_data(prog_data),
    .prog_valid(prog_valid),
    .prog_last(prog_last),
    .prog_ready(prog_ready),
    .instr_writeaddr(instr_writeaddr),
    .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en),
    .cpu_pause(cpu_pause),
    .cpu_reset(cpu_reset),
    .cpu_stopped(cpu_stopped),
    .cpu_error(cpu_error),
    .cpu_accum(cpu_accum),
    .busy(busy),
    .done(done),
    .pass_count(pass_count),
    .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
    bit            lat_ok;
  } wr_t;

  wr_t wr_q[$];
  bit  hs_prev = 1'b0;
  int  rst_tot = 0;
  int  run_tot = 0;

  // Bus monitor: writes, handshake latency, reset and run cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      if (instr_write_en === 1'b1) begin
        wr_q.push_back('{instr_writeaddr, instr_writedata, hs_prev});
      end
      hs_prev = prog_valid && prog_ready;
      if (cpu_reset === 1'b1) rst_tot++;
      if (cpu_pause === 1'b0 && cpu_reset === 1'b0) run_tot++;
    end else begin
      hs_prev = 1'b0;
    end
  end

  int         cpu_delay = 10;
  logic [7:0] cpu_acc_cfg = 8'd0;
  bit         cpu_err_cfg = 1'b0;
  int         cpu_cnt = 0;
  bit         cpu_stop = 1'b0;

  // CPU model: stops cpu_delay unpaused cycles after its reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || cpu_reset) begin
        cpu_cnt  = 0;
        cpu_stop = 1'b0;
      end else if (!cpu_pause) begin
        cpu_cnt++;
        if (cpu_delay != NEVER && cpu_cnt >= cpu_delay) cpu_stop = 1'b1;
      end
      cpu_stopped = cpu_stop;
      cpu_accum   = cpu_stop ? cpu_acc_cfg : 8'($urandom);
      cpu_error   = cpu_stop ? cpu_err_cfg : 1'b0;
    end
  end

  int            exp_pass;
  logic [NP-1:0] exp_mask;
  logic [IW-1:0] sent_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [IW-1:0] w, input bit last,
                           input bit bp);
    int guard = 0;
    if (bp) begin
      prog_valid = 1'b0;
      tick();
    end
    prog_valid = 1'b1;
    prog_data  = w;
    prog_last  = last;
    while (!prog_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!prog_ready) chk("hs_wait", 32'(prog_ready), 32'd1);
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic send_words(input int n, input bit bp);
    logic [IW-1:0] w;
    sent_q.delete();
    for (int i = 0; i < n; i++) begin
      w = IW'($urandom);
      sent_q.push_back(w);
      send_word(w, i == n - 1, bp);
    end
  endtask

  task automatic start_session(input string tag);
    exp_pass = 0;
    exp_mask = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_pc0"}, 32'(pass_count), 32'd0);
    chk({tag, "_fm0"}, 32'(fail_mask), 32'd0);
  endtask

  task automatic run_prog(input int idx, input int n, input int d,
                          input logic [7:0] acc, input bit err,
                          input bit bp);
    bit ovf, tmo, ok;
    int nw, exp_run, guard, wb, rb, ub;
    cpu_delay   = d;
    cpu_acc_cfg = acc;
    cpu_err_cfg = err;
    wb = wr_q.size();
    rb = rst_tot;
    ub = run_tot;
    send_words(n, bp);
    guard = 0;
    while (!(prog_ready || done) && guard < 400) begin
      tick();
      guard++;
    end
    chk($sformatf("p%0d_end", idx), 32'(prog_ready || done), 32'd1);
    ovf = n > DEPTH;
    tmo = !ovf && WDOG && (d == NEVER || d > TO);
    ok  = !ovf && !tmo && !err && acc == 8'd0;
    nw  = ovf ? DEPTH : n;
    exp_run = ovf ? 0 : (tmo ? TO : d);
    chk($sformatf("p%0d_nwr", idx), 32'(wr_q.size() - wb), 32'(nw));
    for (int i = 0; i < nw && wb + i < wr_q.size(); i++) begin
      chk($sformatf("p%0d_a%0d", idx, i), 32'(wr_q[wb + i].a), 32'(i));
      chk($sformatf("p%0d_d%0d", idx, i), 32'(wr_q[wb + i].d),
          32'(sent_q[i]));
      chk($sformatf("p%0d_lat%0d", idx, i), 32'(wr_q[wb + i].lat_ok),
          32'd1);
    end
    chk($sformatf("p%0d_rstlen", idx), 32'(rst_tot - rb),
        32'(ovf ? 0 : RC));
    chk($sformatf("p%0d_runlen", idx), 32'(run_tot - ub), 32'(exp_run));
    if (ok) exp_pass++;
    else exp_mask[idx] = 1'b1;
  endtask

  task automatic end_session(input string tag);
    int guard = 0;
    while (!done && guard < 500) begin
      tick();
      guard++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass_count), 32'(exp_pass));
    chk({tag, "_mask"}, 32'(fail_mask), 32'(exp_mask));
    repeat (3) tick();
    chk({tag, "_hold"}, 32'(done), 32'd1);
    chk({tag, "_pass2"}, 32'(pass_count), 32'(exp_pass));
    chk({tag, "_pause"}, 32'(cpu_pause), 32'd1);
    chk({tag, "_rdy"}, 32'(prog_ready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pause"}, 32'(cpu_pause), 32'd1);
    chk({tag, "_creset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_rdy"}, 32'(prog_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"}, 32'(instr_write_en), 32'd0);
    chk({tag, "_pc"}, 32'(pass_count), 32'd0);
    chk({tag, "_fm"}, 32'(fail_mask), 32'd0);
  endtask

  function automatic logic [7:0] rand_acc();
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(1, 255));
    return 8'd0;
  endfunction

  initial begin
    int guard;
    int ub;

    // Power-on reset.
    repeat (3) tick();
    check_reset_vals("por");
    reset_n = 1'b1;
    tick();
    chk("idle_creset", 32'(cpu_reset), 32'd0);
    chk("idle_pause", 32'(cpu_pause), 32'd1);

    // Basic pass: three 4-word programs.
    start_session("a");
    for (int p = 0; p < NP; p++) run_prog(p, 4, 10, 8'd0, 1'b0, 1'b0);
    end_session("a");

    // Grading under back-pressure; start held high mid-session.
    start_session("b");
    run_prog(0, 4, 10, 8'd0, 1'b0, 1'b1);
    start = 1'b1;
    run_prog(1, 5, 7, 8'h05, 1'b0, 1'b1);
    start = 1'b0;
    run_prog(2, 3, 4, 8'd0, 1'b1, 1'b1);
    end_session("b");

    // Overflow, exact-fit and last-word-drained cases.
    start_session("c");
    run_prog(0, 10, 6, 8'd0, 1'b0, 1'b0);
    run_prog(1, DEPTH, 5, 8'd0, 1'b0, 1'b0);
    run_prog(2, DEPTH + 1, 5, 8'd0, 1'b0, 1'b1);
    end_session("c");

`ifdef EZ8_TEST_RUNNER_TIMEOUT_EN
    // Watchdog expiry, and stop coinciding with the limit.
    start_session("d");
    run_prog(0, 2, 3, 8'd0, 1'b0, 1'b0);
    run_prog(1, 3, NEVER, 8'd0, 1'b0, 1'b0);
    run_prog(2, 2, TO, 8'd0, 1'b0, 1'b0);
    end_session("d");
`endif

    // Abort during RUN of the second program.
    start_session("e");
    run_prog(0, 3, 5, 8'd0, 1'b0, 1'b0);
    chk("e_pc1", 32'(pass_count), 32'd1);
    cpu_delay = NEVER;
    ub = run_tot;
    send_words(4, 1'b0);
    guard = 0;
    while (run_tot - ub < ABORT_AT && guard < 300) begin
      tick();
      guard++;
    end
    chk("e_inrun", 32'(run_tot - ub >= ABORT_AT), 32'd1);
    chk("e_run_pause", 32'(cpu_pause), 32'd0);
    chk("e_run_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("e_abort");
    repeat (2) tick();
    check_reset_vals("e_abort2");
    reset_n = 1'b1;
    tick();

    // Fresh random sessions after the abort.
    for (int s = 0; s < 3; s++) begin
      start_session($sformatf("f%0d", s));
      for (int p = 0; p < NP; p++) begin
        run_prog(p, $urandom_range(1, DEPTH + 2),
                 $urandom_range(2, 12), rand_acc(),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
      end_session($sformatf("f%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
